mcpu_soc_mmio_initiator: RTL

Bus initiator for the SoC MMIO port. It accepts single read or write requests from the core-side load/store path over a valid/ready handshake and drives the MMIO bus as seen by the peripheral decoder: word address, write data, byte-lane write enables. It then samples read data and returns one response per request over a second valid/ready handshake. It sits between the core's uncached access path and the MMIO decoder, and guarantees that write strobes reach peripherals as single-cycle pulses.

---
 rtl/mcpu_soc_mmio_initiator.sv | 116 +++++++++++
 1 files changed

// File: rtl/mcpu_soc_mmio_initiator.sv
// MMIO bus initiator: one read/write request in, one response out.
// Write strobes reach the peripheral bus as single-cycle pulses.
module mcpu_soc_mmio_initiator #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [28:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_write,
  output logic [28:0] mmio_addr,
  output logic [31:0] mmio_data_in,
  output logic [3:0]  mmio_wren,
  input  logic [31:0] mmio_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_write;
  logic [28:0] r_mmio_addr;
  logic [31:0] r_mmio_data_in;
  logic [3:0]  r_mmio_wren;
  logic        r_is_write;
  logic [1:0]  r_cnt;

  logic        w_accept;

  assign w_accept     = req_valid && r_req_ready;
  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_write   = r_resp_write;
  assign mmio_addr    = r_mmio_addr;
  assign mmio_data_in = r_mmio_data_in;
  assign mmio_wren    = r_mmio_wren;

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      r_state        <= IDLE;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= 32'h0;
      r_resp_write   <= 1'b0;
      r_mmio_addr    <= 29'h0;
      r_mmio_data_in <= 32'h0;
      r_mmio_wren    <= 4'h0;
      r_is_write     <= 1'b0;
      r_cnt          <= 2'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mmio_addr    <= req_addr;
            r_mmio_data_in <= req_wdata;
            r_mmio_wren    <= req_wmask;
            r_is_write     <= (req_wmask != 4'h0);
            r_req_ready    <= 1'b0;
            r_state        <= ACCESS;
          end
        end
        ACCESS: begin
          // Strobe lives for this one cycle only
          r_mmio_wren <= 4'h0;
          if (r_is_write) begin
            r_resp_valid <= 1'b1;
            r_resp_write <= 1'b1;
            r_resp_rdata <= 32'h0;
            r_state      <= RESP;
          end else if (RD_LATENCY == 1) begin
            r_resp_valid <= 1'b1;
            r_resp_write <= 1'b0;
            r_resp_rdata <= mmio_data_out;
            r_state      <= RESP;
          end else begin
            r_cnt   <= 2'(RD_LATENCY - 2);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_resp_valid <= 1'b1;
            r_resp_write <= 1'b0;
            r_resp_rdata <= mmio_data_out;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
